// File: rtl/irq_pkg.sv
// irq_pkg: shared types and constants for the interrupt dispatch stage.
//   state_e     - dispatch FSM states (IDLE, PEND, SERV)
//   GRP_A/B/C   - group index values carried in vec_o[5:4]
//   VEC_W       - width of the latched vector {grp_idx, chan}
//   CHAN_W      - width of the encoded channel number
//   grp_encode  - priority encoder for the three group-hit flags
package irq_pkg;

  localparam int VEC_W  = 6;
  localparam int CHAN_W = 4;

  localparam logic [1:0] GRP_A = 2'd0;
  localparam logic [1:0] GRP_B = 2'd1;
  localparam logic [1:0] GRP_C = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    SERV = 2'd2
  } state_e;

  // Group A outranks B, which outranks C. With no hit the result is a
  // don't-care; callers qualify it with the candidate-valid flag.
  function automatic logic [1:0] grp_encode(input logic a, input logic b, input logic c);
    logic [1:0] idx;
    idx = GRP_C;
    if (a)      idx = GRP_A;
    else if (b) idx = GRP_B;
    else if (c) idx = GRP_C;
    return idx;
  endfunction

endpackage

// File: rtl/irq_dispatch_if.sv
// irq_dispatch_if: resolver-side inputs and CPU-side handshake of the
// interrupt dispatch stage, bundled into one interface.
//   grp_a/b/c, chan_code  - resolver group hits and encoded winning channel
//   cpu_ack, eoi          - CPU acknowledge / end-of-interrupt
//   lost_clr              - clears the sticky lost flag
//   irq_o, vec_o          - interrupt request and latched vector
//   isr_mask              - one-hot in-service channel, fed back to the resolver
//   busy_o, lost_o        - dispatcher not idle / an ack timeout occurred
// Modports: master drives the inputs and observes the outputs (resolver +
// CPU side); slave is the dispatcher itself.
interface irq_dispatch_if #(
  parameter int NCH = 9
);
  import irq_pkg::*;

  logic              grp_a;
  logic              grp_b;
  logic              grp_c;
  logic [CHAN_W-1:0] chan_code;
  logic              cpu_ack;
  logic              eoi;
  logic              lost_clr;
  logic              irq_o;
  logic [VEC_W-1:0]  vec_o;
  logic [NCH-1:0]    isr_mask;
  logic              busy_o;
  logic              lost_o;

  modport master (
    output grp_a, grp_b, grp_c, chan_code, cpu_ack, eoi, lost_clr,
    input  irq_o, vec_o, isr_mask, busy_o, lost_o
  );

  modport slave (
    input  grp_a, grp_b, grp_c, chan_code, cpu_ack, eoi, lost_clr,
    output irq_o, vec_o, isr_mask, busy_o, lost_o
  );

endinterface

// File: rtl/irq_stab_filter.sv
// irq_stab_filter: glitch filter for the registered interrupt candidate.
// Counts how many consecutive cycles the same valid candidate has been seen
// and saturates at STABLE_CYCLES.
//   clk, rst     - clock, asynchronous active-high reset
//   clr          - forces the count to zero (dispatcher busy)
//   cand_valid   - registered candidate is valid
//   cand         - registered candidate {grp_idx, chan}
//   stable_hit   - candidate has been stable for STABLE_CYCLES updates
//   stable_vec   - the candidate that qualified
module irq_stab_filter
  import irq_pkg::*;
#(
  parameter int STABLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             cand_valid,
  input  logic [VEC_W-1:0] cand,
  output logic             stable_hit,
  output logic [VEC_W-1:0] stable_vec
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  logic             prev_valid_q, prev_valid_d;
  logic [VEC_W-1:0] prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The previous candidate is always tracked, even while cleared, so the
  // first idle cycle after clr simply restarts counting from one.
  always_comb begin
    prev_d       = cand;
    prev_valid_d = cand_valid;
    if (clr || !cand_valid) begin
      cnt_d = '0;
    end else if (prev_valid_q && (prev_q == cand)) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    end else begin
      cnt_d = CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_valid_q <= 1'b0;
      prev_q       <= '0;
      cnt_q        <= '0;
    end else begin
      prev_valid_q <= prev_valid_d;
      prev_q       <= prev_d;
      cnt_q        <= cnt_d;
    end
  end

  assign stable_hit = (cnt_q == CNT_MAX);
  assign stable_vec = prev_q;

endmodule

// File: rtl/irq_dispatch.sv
// irq_dispatch: sequential dispatch stage behind the 27-channel interrupt
// priority resolver. Registers the resolver outputs, filters glitches,
// raises irq_o with a latched vector and runs the ack / EOI handshake.
//   clk, rst  - clock, asynchronous active-high reset
//   bus       - irq_dispatch_if slave modport (resolver inputs, CPU
//               handshake, irq/vector/mask/status outputs)
module irq_dispatch
  import irq_pkg::*;
#(
  parameter int NCH           = 9,
  parameter int STABLE_CYCLES = 2,
  parameter int ACK_TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  irq_dispatch_if.slave        bus
);

  localparam int TO_W = (ACK_TIMEOUT > 255) ? $clog2(ACK_TIMEOUT + 1) : 8;
  localparam logic [CHAN_W-1:0] NCH_L     = CHAN_W'(NCH);
  localparam logic [NCH-1:0]    MASK_ONE  = {{(NCH-1){1'b0}}, 1'b1};
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(ACK_TIMEOUT - 1);

  logic [2:0]        grp_q;
  logic [CHAN_W-1:0] chan_q;
  logic              cand_valid;
  logic [VEC_W-1:0]  cand;
  logic              stable_hit;
  logic [VEC_W-1:0]  stable_vec;

  state_e            state_q, state_d;
  logic [VEC_W-1:0]  vec_q, vec_d;
  logic [NCH-1:0]    mask_q, mask_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              lost_q, lost_d;
  logic              lost_set;
  logic              timeout_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grp_q  <= '0;
      chan_q <= '0;
    end else begin
      grp_q  <= {bus.grp_a, bus.grp_b, bus.grp_c};
      chan_q <= bus.chan_code;
    end
  end

  // Out-of-range channel codes never form a candidate.
  assign cand_valid = (|grp_q) && (chan_q < NCH_L);
  assign cand       = {grp_encode(grp_q[2], grp_q[1], grp_q[0]), chan_q};

  irq_stab_filter #(
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_stab (
    .clk        (clk),
    .rst        (rst),
    .clr        (state_q != IDLE),
    .cand_valid (cand_valid),
    .cand       (cand),
    .stable_hit (stable_hit),
    .stable_vec (stable_vec)
  );

  // to_cnt counts completed PEND cycles minus one, so matching ACK_TIMEOUT-1
  // leaves PEND after exactly ACK_TIMEOUT cycles with irq_o high.
  assign timeout_hit = (ACK_TIMEOUT != 0) && (to_cnt_q == TO_LAST);

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    mask_d   = mask_q;
    to_cnt_d = to_cnt_q;
    lost_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (stable_hit) begin
          state_d  = PEND;
          vec_d    = stable_vec;
          to_cnt_d = '0;
        end
      end
      PEND: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        // Ack takes precedence over a timeout landing in the same cycle.
        if (bus.cpu_ack) begin
          state_d = SERV;
          mask_d  = MASK_ONE << vec_q[CHAN_W-1:0];
        end else if (timeout_hit) begin
          state_d  = IDLE;
          vec_d    = '0;
          lost_set = 1'b1;
        end
      end
      SERV: begin
        if (bus.eoi) begin
          state_d = IDLE;
          mask_d  = '0;
          vec_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    lost_d = lost_set ? 1'b1 : (bus.lost_clr ? 1'b0 : lost_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      vec_q    <= '0;
      mask_q   <= '0;
      to_cnt_q <= '0;
      lost_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      mask_q   <= mask_d;
      to_cnt_q <= to_cnt_d;
      lost_q   <= lost_d;
    end
  end

  assign bus.irq_o    = (state_q == PEND);
  assign bus.vec_o    = vec_q;
  assign bus.isr_mask = mask_q;
  assign bus.busy_o   = (state_q != IDLE);
  assign bus.lost_o   = lost_q;

endmodule
